// File: rtl/digit_stabilizer_if.sv
// Frame/result bundle between the arg-max stage, the stabilizer and the display/host side.
interface digit_stabilizer_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned N_MATS     = 10
);
   localparam int unsigned IDX_W = $clog2(N_MATS);

   logic [DATA_WIDTH-1:0] max_in;
   logic [IDX_W-1:0]      index_in;
   logic                  valid_in;
   logic                  clear;
   logic [IDX_W-1:0]      digit_out;
   logic                  digit_valid;
   logic                  update;
   logic [DATA_WIDTH-1:0] conf_out;
   logic [15:0]           frame_cnt;
   logic [15:0]           reject_cnt;

   modport master (
      output max_in, index_in, valid_in, clear,
      input  digit_out, digit_valid, update, conf_out, frame_cnt, reject_cnt
   );

   modport slave (
      input  max_in, index_in, valid_in, clear,
      output digit_out, digit_valid, update, conf_out, frame_cnt, reject_cnt
   );
endinterface

// File: rtl/digit_stabilizer.sv
// Temporal filter on arg-max decisions: thresholds the FP16 score and publishes a digit
// once the same class wins CONSEC consecutive accepted frames.
module digit_stabilizer #(
   parameter int unsigned          DATA_WIDTH = 16,
   parameter int unsigned          N_MATS     = 10,
   parameter int unsigned          CONSEC     = 3,
   parameter logic [DATA_WIDTH-1:0] THRESH    = 16'h3800
) (
   input logic               clk,
   input logic               rst_n,
   digit_stabilizer_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(N_MATS);
   localparam int unsigned IW1   = IDX_W + 1;
   localparam logic [IW1-1:0] NMatsV  = IW1'(N_MATS);
   localparam logic [3:0]     ConsecV = 4'(CONSEC);

   typedef enum logic [1:0] {StIdle, StTrack, StLocked} state_e;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      cand_q, cand_d;
   logic [3:0]            streak_q, streak_d;
   logic [IDX_W-1:0]      digit_q, digit_d;
   logic                  dvalid_q, dvalid_d;
   logic                  update_q, update_d;
   logic [DATA_WIDTH-1:0] conf_q, conf_d;
   logic [15:0]           fcnt_q, fcnt_d;
   logic [15:0]           rcnt_q, rcnt_d;

   logic a_nan, b_nan, both_zero, a_eq_b, a_gt_b, accept;
   logic reach, publish;
   logic [DATA_WIDTH-1:0] a, b;

   // FP16 compare of the incoming score against the threshold (cmpfp16 semantics).
   always_comb begin
      a         = bus.max_in;
      b         = THRESH;
      a_nan     = (&a[14:10]) && (|a[9:0]);
      b_nan     = (&b[14:10]) && (|b[9:0]);
      // +0 and -0 compare equal
      both_zero = (a[14:0] == 15'd0) && (b[14:0] == 15'd0);
      a_eq_b    = !a_nan && !b_nan && ((a == b) || both_zero);
      a_gt_b    = 1'b0;
      if (!a_nan && !b_nan && !a_eq_b) begin
         unique case ({a[15], b[15]})
            2'b00:   a_gt_b = a[14:0] > b[14:0];
            2'b01:   a_gt_b = 1'b1;
            2'b10:   a_gt_b = 1'b0;
            default: a_gt_b = a[14:0] < b[14:0];
         endcase
      end
      accept = ({1'b0, bus.index_in} < NMatsV) && (a_gt_b || a_eq_b);
   end

   // Next-state: candidate tracking, publish decision, statistics and clear.
   always_comb begin
      state_d  = state_q;
      cand_d   = cand_q;
      streak_d = streak_q;
      digit_d  = digit_q;
      dvalid_d = dvalid_q;
      update_d = 1'b0;
      conf_d   = conf_q;
      fcnt_d   = fcnt_q;
      rcnt_d   = rcnt_q;
      reach    = 1'b0;
      publish  = 1'b0;

      if (bus.valid_in) begin
         fcnt_d = (fcnt_q == 16'hFFFF) ? fcnt_q : fcnt_q + 16'd1;
         if (accept) begin
            conf_d = bus.max_in;
            if ((state_q != StIdle) && (bus.index_in == cand_q)) begin
               streak_d = (streak_q == ConsecV) ? streak_q : streak_q + 4'd1;
               // only the transition into CONSEC counts; a saturated streak never re-fires
               reach    = (streak_d == ConsecV) && (streak_q != ConsecV);
            end else begin
               cand_d   = bus.index_in;
               streak_d = 4'd1;
               reach    = (ConsecV == 4'd1);
            end
            unique case (state_q)
               StIdle: begin
                  state_d = reach ? StLocked : StTrack;
                  publish = reach;
               end
               StTrack: begin
                  if (reach) state_d = StLocked;
                  publish = reach;
               end
               StLocked: publish = reach && (cand_d != digit_q);
               default:  state_d = StIdle;
            endcase
         end else begin
            rcnt_d   = (rcnt_q == 16'hFFFF) ? rcnt_q : rcnt_q + 16'd1;
            streak_d = 4'd0;
            if (state_q != StLocked) state_d = StIdle;
         end
      end

      if (publish) begin
         digit_d  = cand_d;
         dvalid_d = 1'b1;
         update_d = 1'b1;
      end

      // clear wins over a coincident frame, which is dropped uncounted
      if (bus.clear) begin
         state_d  = StIdle;
         cand_d   = '0;
         streak_d = 4'd0;
         digit_d  = '0;
         dvalid_d = 1'b0;
         update_d = 1'b0;
         conf_d   = '0;
         fcnt_d   = 16'd0;
         rcnt_d   = 16'd0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         cand_q   <= '0;
         streak_q <= 4'd0;
         digit_q  <= '0;
         dvalid_q <= 1'b0;
         update_q <= 1'b0;
         conf_q   <= '0;
         fcnt_q   <= 16'd0;
         rcnt_q   <= 16'd0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         streak_q <= streak_d;
         digit_q  <= digit_d;
         dvalid_q <= dvalid_d;
         update_q <= update_d;
         conf_q   <= conf_d;
         fcnt_q   <= fcnt_d;
         rcnt_q   <= rcnt_d;
      end
   end

   assign bus.digit_out   = digit_q;
   assign bus.digit_valid = dvalid_q;
   assign bus.update      = update_q;
   assign bus.conf_out    = conf_q;
   assign bus.frame_cnt   = fcnt_q;
   assign bus.reject_cnt  = rcnt_q;
endmodule

// File: doc/digit_stabilizer.md
# digit_stabilizer

Temporal filter directly downstream of the arg-max decision stage (`digit_dec`). It consumes one `{max, index, valid}` result per inference frame and applies a confidence threshold on the FP16 winning score. It publishes a digit only after the same class has won `CONSEC` consecutive accepted frames. The stable digit, a one-cycle update strobe and frame/reject statistics are exposed to the display/host logic.

## Interface
- `DATA_WIDTH`, 16: width of the FP16 score.
- `N_MATS`, 10: number of classes; `IDX_W = $clog2(N_MATS)`.
- `CONSEC`, 3: consecutive agreeing accepted frames required to publish; legal range 1..15.
- `THRESH`, 16'h3800: FP16 confidence threshold (0.5).

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `max_in`  in  DATA_WIDTH  FP16 winning score from the arg-max stage.
- `index_in`  in  IDX_W  winning class index.
- `valid_in`  in  1  one-cycle frame strobe; `max_in`/`index_in` are sampled only when high.
- `clear`  in  1  synchronous soft clear.
- `digit_out`  out  IDX_W  published stable digit.
- `digit_valid`  out  1  level; high once any digit has been published.
- `update`  out  1  one-cycle pulse when `digit_out` is (re)published.
- `conf_out`  out  DATA_WIDTH  `max_in` of the last accepted frame.
- `frame_cnt`  out  16  count of `valid_in` frames, saturating at 16'hFFFF.
- `reject_cnt`  out  16  count of rejected frames, saturating at 16'hFFFF.

## Operation
- **Accept rule.** A frame is accepted iff `index_in < N_MATS` and `cmpfp16(max_in, THRESH)` reports `a_gt_b` or `a_eq_b`. Anything else is rejected, including NaN and negative scores.
- **Internal state.** `cand` (IDX_W bits), `streak` (4 bits, saturates at `CONSEC`), FSM state ∈ {IDLE, TRACK, LOCKED}.
- **IDLE** (no candidate, nothing published).
  - Accept: `cand = index_in`, `streak = 1`.
    - If `CONSEC == 1`: go to LOCKED and publish.
    - Otherwise: go to TRACK.
  - Reject: stay in IDLE.
- **TRACK** (nothing published yet).
  - Accept with the same index: `streak++`. When `streak` reaches `CONSEC`, go to LOCKED and publish.
  - Accept with a different index: `cand = index_in`, `streak = 1`.
  - Reject: `streak = 0`, go to IDLE.
- **LOCKED** (`digit_valid = 1`).
  - Candidate tracking continues exactly as in TRACK, but `digit_out` holds.
  - When a candidate reaches `CONSEC`, publish it. This happens only if `cand != digit_out`; a repeat of the current digit never re-pulses `update`.
  - Reject: `streak = 0`, `digit_out` and `digit_valid` held; remain in LOCKED.
- **Publish.** Set `digit_out = cand`, `digit_valid = 1`, and pulse `update` for one cycle.
- **`conf_out`.** Loaded with `max_in` on every accepted frame, whether or not it publishes.
- **Counters.**
  - `frame_cnt` increments on every `valid_in`.
  - `reject_cnt` increments on every rejected frame.
  - Both saturate; neither wraps.
- **`clear`.** Behaves exactly as reset (all outputs and state to reset values). It has priority over a simultaneous `valid_in`; that frame is dropped and not counted.

## Timing
- **Reset.** While `rst_n` is low, immediately and asynchronously: `digit_out = 0`, `digit_valid = 0`, `update = 0`, `conf_out = 0`, `frame_cnt = 0`, `reject_cnt = 0`, FSM = IDLE, `cand = 0`, `streak = 0`. Reset mid-TRACK or mid-LOCKED discards all history.
- **Registered outputs.** All outputs are registered; the threshold compare is combinational on the inputs.
- **Latency.** Effects of a frame sampled at edge N (state change, `update`, `conf_out`, counter increments) are visible after edge N. `update` is high for exactly the cycle following that edge.
- **Back-to-back frames.** `valid_in` on consecutive cycles is legal; each cycle is processed independently at full rate. There is no back-pressure.
- **Ignored cycles.** Cycles with `valid_in` low change nothing except clearing `update`.

## Test plan
- **Reset.**
  - Stimulus: assert `rst_n` low mid-stream.
  - Required: all outputs read 0 in the same cycle, before the next edge. After release, two frames of index 7 at 16'h3C00 do not publish.
- **Basic lock.**
  - Stimulus: three frames of index 7 at `max_in` = 16'h3C00.
  - Required: `update` pulses once after the third frame; `digit_out` = 7, `digit_valid` = 1, `conf_out` = 16'h3C00, `frame_cnt` = 3, `reject_cnt` = 0.
- **Reject breaks streak.**
  - Stimulus: index 7 frames with scores 16'h3C00, 16'h3C00, 16'h3400 (reject), 16'h3C00, 16'h3C00.
  - Required: no publish after those five frames; `reject_cnt` = 1. A sixth frame of index 7 at 16'h3C00 publishes 7.
- **Switch while locked.**
  - Stimulus: locked on 7, then indices 2, 2, 7, 2, 2, 2, all at 16'h3C00.
  - Required: `digit_out` stays 7 until the final frame, then becomes 2 with exactly one `update` pulse. Neither the intervening 7 nor any other frame pulses `update`.
- **Boundary accepts and rejects.**
  - Stimulus: `max_in` values 16'h3800 (equal to threshold), 16'hBC00 (negative), 16'h7E00 (NaN), plus `index_in` = 12 at 16'h3C00.
  - Required: only the 16'h3800 frame is accepted; `reject_cnt` increases by 3.
- **Clear and saturation.**
  - Stimulus: `clear` asserted together with `valid_in` while locked.
  - Required: all outputs 0, `frame_cnt` = 0, the frame is not counted.
  - Stimulus: 65,540 frames.
  - Required: `frame_cnt` holds at 16'hFFFF.
